// File: rtl/ama_riscv_rf_wb_arb_pkg.sv
// Shared register-file types and helpers used by the writeback arbiter.
// Also holds the LLU result FIFO entry format.
package ama_riscv_rf_wb_arb_pkg;

  typedef logic [31:0] arch_width_t;
  typedef logic [4:0]  rf_addr_t;

  typedef struct packed {
    logic rd;
    logic rdp;
  } rf_we_t;

  localparam rf_addr_t RF_X0_ZERO = 5'd0;
  localparam rf_addr_t RF_X31_T6  = 5'd31;

  localparam int unsigned RF_WB_FIFO_DEPTH = 2;

  typedef struct packed {
    rf_addr_t    rd;
    logic        rdp;
    arch_width_t data;
    arch_width_t data_p;
  } rf_wb_req_t;

  function automatic rf_addr_t get_rdp(input rf_addr_t rd);
    return rd + 5'd1;
  endfunction

  // A pair must start on an even register below x31.
  function automatic logic pair_illegal(input rf_wb_req_t req);
    return req.rdp && (req.rd[0] || (req.rd == RF_X31_T6));
  endfunction

  function automatic logic [31:0] pending_mask(input rf_wb_req_t req);
    logic [31:0] m;
    m = '0;
    if (req.rd != RF_X0_ZERO) begin
      m[req.rd] = 1'b1;
      if (req.rdp && !pair_illegal(req)) m[get_rdp(req.rd)] = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/ama_riscv_rf_wb_arb_if.sv
// Producer-side bundle: pipeline writeback request and LLU valid/ready result.
interface ama_riscv_rf_wb_arb_if;
  import ama_riscv_rf_wb_arb_pkg::*;

  logic        pipe_v;
  logic        pipe_rdp;
  rf_addr_t    pipe_rd;
  arch_width_t pipe_data;
  arch_width_t pipe_data_p;
  logic        pipe_stall;

  logic        llu_valid;
  logic        llu_ready;
  logic        llu_rdp;
  rf_addr_t    llu_rd;
  arch_width_t llu_data;
  arch_width_t llu_data_p;

  modport master (
    output pipe_v, pipe_rdp, pipe_rd, pipe_data, pipe_data_p,
    input  pipe_stall,
    output llu_valid, llu_rdp, llu_rd, llu_data, llu_data_p,
    input  llu_ready
  );

  modport slave (
    input  pipe_v, pipe_rdp, pipe_rd, pipe_data, pipe_data_p,
    output pipe_stall,
    input  llu_valid, llu_rdp, llu_rd, llu_data, llu_data_p,
    output llu_ready
  );
endinterface

// File: rtl/ama_riscv_rf_wb_arb_fifo.sv
// Small circular FIFO buffering LLU writeback requests; exposes every entry
// so the arbiter can build the pending-write mask.
module ama_riscv_wb_fifo
  import ama_riscv_rf_wb_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push,
  input  rf_wb_req_t push_req,
  input  logic       pop,
  output logic       full,
  output logic       empty,
  output rf_wb_req_t head,
  output logic       [RF_WB_FIFO_DEPTH-1:0] ent_vld,
  output rf_wb_req_t ent [RF_WB_FIFO_DEPTH]
);

  localparam int unsigned PTR_W = $clog2(RF_WB_FIFO_DEPTH);

  logic [PTR_W-1:0]            wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]            rd_ptr_q, rd_ptr_d;
  logic [RF_WB_FIFO_DEPTH-1:0] vld_q, vld_d;
  rf_wb_req_t                  mem_q [RF_WB_FIFO_DEPTH];
  rf_wb_req_t                  mem_d [RF_WB_FIFO_DEPTH];
  logic                        push_ok, pop_ok;

  assign full    = &vld_q;
  assign empty   = ~|vld_q;
  assign head    = mem_q[rd_ptr_q];
  assign ent_vld = vld_q;
  assign ent     = mem_q;

  always_comb begin
    push_ok  = push && !full;
    pop_ok   = pop && !empty;
    wr_ptr_d = wr_ptr_q + PTR_W'(push_ok);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop_ok);
    vld_d    = vld_q;
    mem_d    = mem_q;
    if (pop_ok) vld_d[rd_ptr_q] = 1'b0;
    if (push_ok) begin
      vld_d[wr_ptr_q] = 1'b1;
      mem_d[wr_ptr_q] = push_req;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      vld_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      vld_q    <= vld_d;
    end
  end

  // Payload storage carries no reset; entry validity is the only control.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/ama_riscv_rf_wb_arb.sv
// Register-file writeback arbiter: pipeline writeback vs buffered LLU results,
// with starvation guard, paired-write sanitisation and pending-write mask.
module ama_riscv_rf_wb_arb
  import ama_riscv_rf_wb_arb_pkg::*;
#(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  ama_riscv_rf_wb_arb_if.slave  bus,
  output rf_we_t                we,
  output rf_addr_t              addr_d,
  output arch_width_t           data_d,
  output arch_width_t           data_dp,
  output logic [31:0]           llu_pending,
  output logic                  err_rdp
);

  localparam int unsigned CNT_W = ($clog2(STARVE_MAX + 1) > 3) ? $clog2(STARVE_MAX + 1) : 3;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

  rf_wb_req_t pipe_req, llu_req, fifo_head, sel;
  rf_wb_req_t fifo_ent [RF_WB_FIFO_DEPTH];
  logic [RF_WB_FIFO_DEPTH-1:0] fifo_ent_vld;
  logic fifo_full, fifo_empty, fifo_push;
  logic starved, grant_head, grant_pipe, any_grant, wr_ok;

  logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;
  rf_we_t           we_q, we_d;
  rf_addr_t         waddr_q, waddr_d;
  arch_width_t      wdata_q, wdata_d;
  arch_width_t      wdata_p_q, wdata_p_d;
  logic             err_q, err_d;

  assign fifo_push      = bus.llu_valid && bus.llu_ready;
  assign bus.llu_ready  = !fifo_full;
  assign bus.pipe_stall = bus.pipe_v && starved;

  ama_riscv_wb_fifo u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (fifo_push),
    .push_req (llu_req),
    .pop      (grant_head),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .head     (fifo_head),
    .ent_vld  (fifo_ent_vld),
    .ent      (fifo_ent)
  );

  always_comb begin
    pipe_req = '{rd: bus.pipe_rd, rdp: bus.pipe_rdp, data: bus.pipe_data, data_p: bus.pipe_data_p};
    llu_req  = '{rd: bus.llu_rd, rdp: bus.llu_rdp, data: bus.llu_data, data_p: bus.llu_data_p};

    starved    = !fifo_empty && (starve_cnt_q >= CNT_MAX);
    grant_head = !fifo_empty && (!bus.pipe_v || starved);
    grant_pipe = bus.pipe_v && !grant_head;
    any_grant  = grant_head || grant_pipe;
    sel        = grant_head ? fifo_head : pipe_req;

    if (fifo_empty || grant_head)  starve_cnt_d = '0;
    else if (starve_cnt_q < CNT_MAX) starve_cnt_d = starve_cnt_q + CNT_W'(1);
    else                           starve_cnt_d = starve_cnt_q;

    // x0 writes are granted and popped but never reach the register file.
    wr_ok     = any_grant && (sel.rd != RF_X0_ZERO);
    we_d.rd   = wr_ok;
    we_d.rdp  = wr_ok && sel.rdp && !pair_illegal(sel);
    err_d     = any_grant && pair_illegal(sel);
    waddr_d   = any_grant ? sel.rd     : waddr_q;
    wdata_d   = any_grant ? sel.data   : wdata_q;
    wdata_p_d = any_grant ? sel.data_p : wdata_p_q;
  end

  always_comb begin
    llu_pending = '0;
    for (int i = 0; i < RF_WB_FIFO_DEPTH; i++) begin
      if (fifo_ent_vld[i]) llu_pending = llu_pending | pending_mask(fifo_ent[i]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt_q <= '0;
      we_q         <= '0;
      waddr_q      <= '0;
      wdata_q      <= '0;
      wdata_p_q    <= '0;
      err_q        <= 1'b0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
      we_q         <= we_d;
      waddr_q      <= waddr_d;
      wdata_q      <= wdata_d;
      wdata_p_q    <= wdata_p_d;
      err_q        <= err_d;
    end
  end

  assign we      = we_q;
  assign addr_d  = waddr_q;
  assign data_d  = wdata_q;
  assign data_dp = wdata_p_q;
  assign err_rdp = err_q;

`ifndef SYNTHESIS
  a_pipe_hold: assert property (@(posedge clk) disable iff (!rst_n)
    bus.pipe_stall |=> (bus.pipe_v && $stable(bus.pipe_rd) && $stable(bus.pipe_rdp)
                        && $stable(bus.pipe_data) && $stable(bus.pipe_data_p)));
  a_no_push_full: assert property (@(posedge clk) disable iff (!rst_n)
    !(fifo_push && fifo_full));
`endif

endmodule

// File: tb/tb_ama_riscv_rf_wb_arb.sv
// Scoreboard bench for the writeback arbiter: stimulus queues expected RF
// writes, an independent monitor pops and compares whenever we is asserted.
module tb_ama_riscv_rf_wb_arb;
  import ama_riscv_rf_wb_arb_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  ama_riscv_rf_wb_arb_if bus();

  rf_we_t      we;
  rf_addr_t    addr_d;
  arch_width_t data_d, data_dp;
  logic [31:0] llu_pending;
  logic        err_rdp;

  ama_riscv_rf_wb_arb #(.STARVE_MAX(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .we          (we),
    .addr_d      (addr_d),
    .data_d      (data_d),
    .data_dp     (data_dp),
    .llu_pending (llu_pending),
    .err_rdp     (err_rdp)
  );

  typedef struct {
    string       name;
    rf_addr_t    addr;
    logic        we_rd;
    logic        we_rdp;
    arch_width_t data;
    arch_width_t data_p;
    logic        err;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   vectors = 0;
  int   miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic exp_wr(input string name, input rf_addr_t rd, input logic we_rd, input logic we_rdp,
                        input arch_width_t d, input arch_width_t dp, input logic err);
    exp_t e;
    e.name = name; e.addr = rd; e.we_rd = we_rd; e.we_rdp = we_rdp;
    e.data = d; e.data_p = dp; e.err = err;
    sb_q.push_back(e);
  endtask

  task automatic set_pipe(input logic v, input rf_addr_t rd, input logic rdp,
                          input arch_width_t d, input arch_width_t dp);
    bus.pipe_v = v; bus.pipe_rd = rd; bus.pipe_rdp = rdp;
    bus.pipe_data = d; bus.pipe_data_p = dp;
  endtask

  task automatic set_llu(input logic v, input rf_addr_t rd, input logic rdp,
                         input arch_width_t d, input arch_width_t dp);
    bus.llu_valid = v; bus.llu_rd = rd; bus.llu_rdp = rdp;
    bus.llu_data = d; bus.llu_data_p = dp;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One-cycle pipeline request; the write shows up after the following edge.
  task automatic pipe_once(input string name, input rf_addr_t rd, input logic rdp,
                           input arch_width_t d, input arch_width_t dp);
    set_pipe(1'b1, rd, rdp, d, dp);
    @(negedge clk);
    check({name, "_stall"}, 32'(bus.pipe_stall), 32'd0);
    step();
    set_pipe(1'b0, 5'd0, 1'b0, 32'd0, 32'd0);
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1 && (we.rd || we.rdp)) begin
      if (sb_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_write: got we=%b addr=%0d, expected no write", {we.rd, we.rdp}, addr_d);
      end else begin
        mon_e = sb_q.pop_front();
        check({mon_e.name, "_we"},   32'({we.rd, we.rdp}), 32'({mon_e.we_rd, mon_e.we_rdp}));
        check({mon_e.name, "_addr"}, 32'(addr_d), 32'(mon_e.addr));
        check({mon_e.name, "_data"}, data_d, mon_e.data);
        if (mon_e.we_rdp) check({mon_e.name, "_data_p"}, data_dp, mon_e.data_p);
        check({mon_e.name, "_err"},  32'(err_rdp), 32'(mon_e.err));
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    set_pipe(1'b0, 5'd0, 1'b0, 32'd0, 32'd0);
    set_llu(1'b0, 5'd0, 1'b0, 32'd0, 32'd0);

    @(negedge clk);
    check("rst_we",      32'({we.rd, we.rdp}), 32'd0);
    check("rst_addr",    32'(addr_d), 32'd0);
    check("rst_data",    data_d, 32'd0);
    check("rst_data_p",  data_dp, 32'd0);
    check("rst_err",     32'(err_rdp), 32'd0);
    check("rst_pending", llu_pending, 32'd0);
    check("rst_ready",   32'(bus.llu_ready), 32'd1);
    step();
    rst_n = 1'b1;
    step();

    // Pipeline-only writes, legal pair, illegal pairs, x0.
    exp_wr("pipe_x5", 5'd5, 1'b1, 1'b0, 32'hA5, 32'd0, 1'b0);
    pipe_once("pipe_x5", 5'd5, 1'b0, 32'hA5, 32'd0);
    exp_wr("pair_x10", 5'd10, 1'b1, 1'b1, 32'h11, 32'h22, 1'b0);
    pipe_once("pair_x10", 5'd10, 1'b1, 32'h11, 32'h22);
    exp_wr("pair_x7", 5'd7, 1'b1, 1'b0, 32'h77, 32'd0, 1'b1);
    pipe_once("pair_x7", 5'd7, 1'b1, 32'h77, 32'h78);
    exp_wr("pair_x31", 5'd31, 1'b1, 1'b0, 32'h31, 32'd0, 1'b1);
    pipe_once("pair_x31", 5'd31, 1'b1, 32'h31, 32'h32);
    pipe_once("single_x0", 5'd0, 1'b0, 32'hDEAD, 32'd0);
    @(negedge clk);
    check("x0_we", 32'({we.rd, we.rdp}), 32'd0);
    check("err_one_pulse", 32'(err_rdp), 32'd0);
    step();

    // LLU fill while the pipeline issues dropped x0 writes, then drain.
    set_pipe(1'b1, 5'd0, 1'b0, 32'd0, 32'd0);
    set_llu(1'b1, 5'd3, 1'b0, 32'h33, 32'd0);
    exp_wr("llu_x3", 5'd3, 1'b1, 1'b0, 32'h33, 32'd0, 1'b0);
    exp_wr("llu_x4", 5'd4, 1'b1, 1'b1, 32'h44, 32'h45, 1'b0);
    step();
    set_llu(1'b1, 5'd4, 1'b1, 32'h44, 32'h45);
    step();
    set_llu(1'b0, 5'd0, 1'b0, 32'd0, 32'd0);
    set_pipe(1'b0, 5'd0, 1'b0, 32'd0, 32'd0);
    @(negedge clk);
    // x3 -> bit 3, pair x4/x5 -> bits 4 and 5.
    check("fill_pending", llu_pending, 32'h38);
    check("fill_ready", 32'(bus.llu_ready), 32'd0);
    step();
    @(negedge clk);
    check("llu_x3_latency", {26'd0, we.rd, addr_d}, {26'd0, 1'b1, 5'd3});
    step();
    @(negedge clk);
    check("drain_pending", llu_pending, 32'd0);
    check("drain_ready", 32'(bus.llu_ready), 32'd1);
    step();

    // Starvation: x8 waits behind a continuous pipeline stream of x9.
    for (int k = 0; k < 7; k++) begin
      if (k == 0) begin
        set_pipe(1'b1, 5'd9, 1'b0, 32'h99, 32'd0);
        set_llu(1'b1, 5'd8, 1'b0, 32'h88, 32'd0);
      end else if (k == 1) begin
        set_llu(1'b0, 5'd0, 1'b0, 32'd0, 32'd0);
      end
      if (k == 5) exp_wr("starve_x8", 5'd8, 1'b1, 1'b0, 32'h88, 32'd0, 1'b0);
      else        exp_wr($sformatf("stream_x9_%0d", k), 5'd9, 1'b1, 1'b0, 32'h99, 32'd0, 1'b0);
      @(negedge clk);
      check($sformatf("starve_stall_c%0d", k), 32'(bus.pipe_stall), (k == 5) ? 32'd1 : 32'd0);
      step();
    end
    set_pipe(1'b0, 5'd0, 1'b0, 32'd0, 32'd0);
    step();

    // Reset with a full FIFO discards both entries.
    set_pipe(1'b1, 5'd0, 1'b0, 32'd0, 32'd0);
    set_llu(1'b1, 5'd12, 1'b0, 32'hC, 32'd0);
    step();
    set_llu(1'b1, 5'd14, 1'b1, 32'hE, 32'hF);
    step();
    set_llu(1'b0, 5'd0, 1'b0, 32'd0, 32'd0);
    set_pipe(1'b0, 5'd0, 1'b0, 32'd0, 32'd0);
    @(negedge clk);
    check("full_ready", 32'(bus.llu_ready), 32'd0);
    check("full_pending", llu_pending, 32'hD000);
    rst_n = 1'b0;
    #1;
    check("midrst_pending", llu_pending, 32'd0);
    check("midrst_ready", 32'(bus.llu_ready), 32'd1);
    check("midrst_we", 32'({we.rd, we.rdp}), 32'd0);
    step();
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check($sformatf("post_rst_we_%0d", i), 32'({we.rd, we.rdp}), 32'd0);
    end
    step();
    step();
    check("sb_drained", 32'(sb_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
